// File: rtl/rtl_stream_pkg.sv
// Shared stream definitions for the ingress FIFO and the core-side consumer.
// Keeps the payload width and the occupancy-counter width rule in one place.
package rtl_stream_pkg;

    localparam int DATA_W_DEF = 32;

    typedef logic [DATA_W_DEF-1:0] stream_word_t;

    // Occupancy needs one more bit than the address so that DEPTH itself is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rtl_fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module rtl_fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rtl_stream_fifo.sv
// Valid/ready ingress buffer in front of the core datapath, with registered fill
// level, almost-full/almost-empty flags and a high-water mark.
module rtl_stream_fifo
    import rtl_stream_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [lvl_w(DEPTH)-1:0]   hwm
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int LVL_W  = lvl_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] hwm_q, hwm_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             rst_state_q, rst_state_d;

    logic empty, full, push, pop;

    // Flags come only from registered pointers, so neither handshake input
    // reaches the opposite handshake output combinationally.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign s_ready = ~full & ~rst_state_q;
    assign m_valid = ~empty;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        hwm_d       = hwm_q;
        rst_state_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            hwm_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
            // level never exceeds DEPTH, so the max also saturates there.
            hwm_d   = (level_d > hwm_q) ? level_d : hwm_q;
        end
        afull_d  = (level_d >= LVL_W'(AFULL_TH));
        aempty_d = (level_d <= LVL_W'(AEMPTY_TH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            hwm_q       <= '0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            rst_state_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            hwm_q       <= hwm_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            rst_state_q <= rst_state_d;
        end
    end

    rtl_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (s_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (m_data)
    );

    assign level        = level_q;
    assign hwm          = hwm_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

endmodule

// File: tb/tb_rtl_stream_fifo.sv
// Directed bench for rtl_stream_fifo: reset, fill/drain, full corner, wrap
// streaming, flush priority and mid-burst reset.
module tb_rtl_stream_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [4:0]  level;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  hwm;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rtl_stream_fifo #(
        .DATA_W    (32),
        .DEPTH     (16),
        .AFULL_TH  (12),
        .AEMPTY_TH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .hwm          (hwm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so registered outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        step();
        step();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_level",   32'(level), 32'd0);
        chk("rst_aempty",  32'(almost_empty), 32'd1);
        chk("rst_afull",   32'(almost_full), 32'd0);
        chk("rst_hwm",     32'(hwm), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);

        // Fill 1..16 with the consumer stalled
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1; s_data = 32'(i);
            step();
            chk("fill_level", 32'(level), 32'(i));
            chk("fill_afull", 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
            if (i == 1) begin
                chk("fill_first_m_valid", 32'(m_valid), 32'd1);
                chk("fill_first_m_data", m_data, 32'h1);
            end
        end
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_hwm",     32'(hwm), 32'd16);
        chk("full_aempty",  32'(almost_empty), 32'd0);

        // Full with push and pop requested: only the pop happens
        s_data = 32'h99; m_ready = 1'b1;
        chk("full_head", m_data, 32'h1);
        step();
        s_valid = 1'b0;
        chk("fullpp_level",   32'(level), 32'd15);
        chk("fullpp_s_ready", 32'(s_ready), 32'd1);
        chk("fullpp_head",    m_data, 32'h2);

        for (int e = 2; e <= 16; e++) begin
            chk("drain_m_valid", 32'(m_valid), 32'd1);
            chk("drain_data", m_data, 32'(e));
            step();
        end
        m_ready = 1'b0;
        chk("drained_level",   32'(level), 32'd0);
        chk("drained_m_valid", 32'(m_valid), 32'd0);
        chk("drained_aempty",  32'(almost_empty), 32'd1);
        chk("drained_hwm",     32'(hwm), 32'd16);

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_hwm", 32'(hwm), 32'd0);

        // Prime 8 words, then stream 40 with simultaneous push/pop
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1; s_data = 32'h100 + 32'(k);
            step();
        end
        chk("prime_level", 32'(level), 32'd8);
        m_ready = 1'b1;
        for (int j = 0; j < 40; j++) begin
            s_data = 32'h108 + 32'(j);
            chk("stream_data", m_data, 32'h100 + 32'(j));
            step();
            chk("stream_level", 32'(level), 32'd8);
        end
        chk("stream_hwm", 32'(hwm), 32'd8);
        chk("stream_tail_head", m_data, 32'h128);
        s_valid = 1'b0; m_ready = 1'b0;

        // Flush beats a concurrent push
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_data = 32'h50 + 32'(k);
            step();
        end
        chk("pre_flush_level", 32'(level), 32'd5);
        flush = 1'b1; s_data = 32'hDEAD;
        step();
        flush = 1'b0; s_valid = 1'b0;
        chk("flush_level",   32'(level), 32'd0);
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        chk("flush_hwm2",    32'(hwm), 32'd0);
        chk("flush_aempty",  32'(almost_empty), 32'd1);
        s_valid = 1'b1; s_data = 32'h77;
        step();
        s_valid = 1'b0;
        chk("after_flush_data",  m_data, 32'h77);
        chk("after_flush_level", 32'(level), 32'd1);

        // Reset in the middle of a burst
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 7; k++) begin
            s_valid = 1'b1; s_data = 32'h200 + 32'(k);
            step();
        end
        chk("burst_level", 32'(level), 32'd7);
        rst = 1'b1;
        #2;
        chk("midrst_level",   32'(level), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_hwm",     32'(hwm), 32'd0);
        chk("midrst_aempty",  32'(almost_empty), 32'd1);
        chk("midrst_afull",   32'(almost_full), 32'd0);
        s_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rerel_s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1; s_data = 32'hA5;
        step();
        s_valid = 1'b0;
        chk("a5_data",    m_data, 32'hA5);
        chk("a5_level",   32'(level), 32'd1);
        chk("a5_m_valid", 32'(m_valid), 32'd1);
        chk("a5_hwm",     32'(hwm), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
